// File: rtl/smooth_fade_sequencer.sv
// SMOOTH-mode colour generator: fades one LSB per committed step through the
// 15-entry palette, holding each reached colour, committing only on PWM sync.
module smooth_fade_sequencer #(
   parameter int STEP_DIV   = 117_188,
   parameter int HOLD_STEPS = 64
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       pause,
   input  logic       sync,
   output logic [7:0] red_o,
   output logic [7:0] green_o,
   output logic [7:0] blue_o,
   output logic [3:0] index_o,
   output logic       busy,
   output logic       wrap_o
);

   // state  | meaning
   // S_IDLE | disabled; colour and index frozen
   // S_FADE | stepping each channel one LSB per commit toward the target
   // S_HOLD | target reached; counting HOLD_STEPS commits before advancing

   localparam int PW = $clog2(STEP_DIV);
   localparam int HW = $clog2(HOLD_STEPS + 1);
   localparam logic [PW-1:0] PRESC_MAX = PW'(STEP_DIV - 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_STEPS);

   typedef enum logic [1:0] {S_IDLE, S_FADE, S_HOLD} state_t;

   function automatic logic [23:0] palette(input logic [3:0] idx);
      case (idx)
         4'd0:    palette = 24'hFF0000;
         4'd1:    palette = 24'hFF4000;
         4'd2:    palette = 24'hFF5500;
         4'd3:    palette = 24'hFF8000;
         4'd4:    palette = 24'hFFD500;
         4'd5:    palette = 24'h00FF00;
         4'd6:    palette = 24'h99FF99;
         4'd7:    palette = 24'h00CCAA;
         4'd8:    palette = 24'h4DC3FF;
         4'd9:    palette = 24'h0066CC;
         4'd10:   palette = 24'h0000FF;
         4'd11:   palette = 24'hB3CCFF;
         4'd12:   palette = 24'hFFE6FB;
         4'd13:   palette = 24'hFF80BF;
         4'd14:   palette = 24'hFF3399;
         default: palette = 24'hFF0000;
      endcase
   endfunction

   function automatic logic [7:0] step_ch(input logic [7:0] cur, input logic [7:0] tgt);
      if (cur < tgt)      step_ch = cur + 8'd1;
      else if (cur > tgt) step_ch = cur - 8'd1;
      else                step_ch = cur;
   endfunction

   state_t        r_state, w_state;
   logic [PW-1:0] r_presc, w_presc;
   logic          r_pend,  w_pend;
   logic [HW-1:0] r_hold,  w_hold;
   logic [7:0]    r_red,   w_red;
   logic [7:0]    r_green, w_green;
   logic [7:0]    r_blue,  w_blue;
   logic [3:0]    r_index, w_index;
   logic          r_busy,  w_busy;
   logic          r_wrap,  w_wrap;

   logic [23:0]   w_tgt;
   logic          w_tick;
   logic          w_commit;
   logic [7:0]    w_step_r, w_step_g, w_step_b;
   logic          w_reached;
   logic [3:0]    w_idx_inc;
   logic [HW-1:0] w_hold_inc;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_presc <= '0;
         r_pend  <= 1'b0;
         r_hold  <= '0;
         r_red   <= 8'hFF;
         r_green <= 8'h00;
         r_blue  <= 8'h00;
         r_index <= 4'd0;
         r_busy  <= 1'b0;
         r_wrap  <= 1'b0;
      end else begin
         r_state <= w_state;
         r_presc <= w_presc;
         r_pend  <= w_pend;
         r_hold  <= w_hold;
         r_red   <= w_red;
         r_green <= w_green;
         r_blue  <= w_blue;
         r_index <= w_index;
         r_busy  <= w_busy;
         r_wrap  <= w_wrap;
      end
   end

   always_comb begin
      w_tgt      = palette(r_index);
      w_tick     = (r_state != S_IDLE) && !pause && (r_presc == PRESC_MAX);
      w_commit   = (r_state != S_IDLE) && r_pend && sync && !pause;
      w_step_r   = step_ch(r_red,   w_tgt[23:16]);
      w_step_g   = step_ch(r_green, w_tgt[15:8]);
      w_step_b   = step_ch(r_blue,  w_tgt[7:0]);
      w_reached  = ({w_step_r, w_step_g, w_step_b} == w_tgt);
      w_idx_inc  = (r_index == 4'd14) ? 4'd0 : r_index + 4'd1;
      w_hold_inc = r_hold + HW'(1);

      w_state = r_state;
      w_presc = r_presc;
      w_pend  = r_pend;
      w_hold  = r_hold;
      w_red   = r_red;
      w_green = r_green;
      w_blue  = r_blue;
      w_index = r_index;
      w_wrap  = 1'b0;

      if (!en) begin
         // Disable wins over a coincident commit; colour and index stay put.
         w_state = S_IDLE;
         w_presc = '0;
         w_pend  = 1'b0;
         w_hold  = '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               w_state = S_FADE;
               w_index = w_idx_inc;
               w_wrap  = (r_index == 4'd14);
            end
            default: begin
               if (!pause) w_presc = (r_presc == PRESC_MAX) ? '0 : r_presc + PW'(1);
               // A tick arriving while a step is still waiting for sync is dropped.
               if (w_commit)    w_pend = 1'b0;
               else if (w_tick) w_pend = 1'b1;
               if (w_commit) begin
                  if (r_state == S_FADE) begin
                     w_red   = w_step_r;
                     w_green = w_step_g;
                     w_blue  = w_step_b;
                     if (w_reached) begin
                        w_state = S_HOLD;
                        w_hold  = '0;
                     end
                  end else if (w_hold_inc == HOLD_LAST) begin
                     w_state = S_FADE;
                     w_hold  = '0;
                     w_index = w_idx_inc;
                     w_wrap  = (r_index == 4'd14);
                  end else begin
                     w_hold = w_hold_inc;
                  end
               end
            end
         endcase
      end

      w_busy = (w_state != S_IDLE);
   end

   assign red_o   = r_red;
   assign green_o = r_green;
   assign blue_o  = r_blue;
   assign index_o = r_index;
   assign busy    = r_busy;
   assign wrap_o  = r_wrap;

endmodule

// File: tb/tb_smooth_fade_sequencer.sv
// Bench for smooth_fade_sequencer: fixed-edge vector table plus a colour/index
// change scoreboard fed by an independent palette-stepping model.
module tb_smooth_fade_sequencer;
   localparam int STEP_DIV = 4;
   localparam int HOLD     = 2;

   logic       clk = 1'b0;
   logic       rst, en, pause, sync;
   logic [7:0] red_o, green_o, blue_o;
   logic [3:0] index_o;
   logic       busy, wrap_o;

   smooth_fade_sequencer #(.STEP_DIV(STEP_DIV), .HOLD_STEPS(HOLD)) dut (
      .clk(clk), .rst(rst), .en(en), .pause(pause), .sync(sync),
      .red_o(red_o), .green_o(green_o), .blue_o(blue_o),
      .index_o(index_o), .busy(busy), .wrap_o(wrap_o)
   );

   always #5 clk = ~clk;

   int edge_n = 0;
   always @(posedge clk) edge_n <= edge_n + 1;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int         e;
      logic [23:0] rgb;
      logic [3:0]  idx;
   } ev_t;

   typedef struct {
      string       name;
      int          ofs;
      logic        en;
      logic        pause;
      logic [23:0] rgb;
      logic [3:0]  idx;
      logic        busy;
   } vec_t;

   ev_t         sbq[$];
   vec_t        vt[$];
   logic [23:0] pal [15];
   bit          mon_on = 1'b0;
   logic [27:0] mon_last = '0;
   int          wrap_edge = -1;
   int          wraps = 0;
   bit          sync_periodic = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, want %0h (edge %0d)", nm, act, exp, edge_n);
      end
   endtask

   task automatic push(input int e, input logic [23:0] rgb, input logic [3:0] idx);
      ev_t ev;
      ev.e = e; ev.rgb = rgb; ev.idx = idx;
      sbq.push_back(ev);
   endtask

   task automatic add_vec(input string nm, input int ofs, input logic [23:0] rgb,
                          input logic [3:0] idx, input logic b);
      vec_t v;
      v.name = nm; v.ofs = ofs; v.en = 1'b1; v.pause = 1'b0;
      v.rgb = rgb; v.idx = idx; v.busy = b;
      vt.push_back(v);
   endtask

   task automatic wait_edge(input int t);
      while (edge_n < t) @(negedge clk);
   endtask

   function automatic logic [23:0] step_rgb(input logic [23:0] c, input logic [23:0] t);
      logic [23:0] r;
      for (int i = 0; i < 3; i++) begin
         if (c[i*8 +: 8] < t[i*8 +: 8])      r[i*8 +: 8] = c[i*8 +: 8] + 8'd1;
         else if (c[i*8 +: 8] > t[i*8 +: 8]) r[i*8 +: 8] = c[i*8 +: 8] - 8'd1;
         else                                r[i*8 +: 8] = c[i*8 +: 8];
      end
      return r;
   endfunction

   // Scoreboard: every change of {colour, index} must be the next expected event, on its edge.
   always @(negedge clk) begin : mon
      logic [27:0] cur;
      ev_t         ev;
      if (mon_on) begin
         cur = {red_o, green_o, blue_o, index_o};
         if (cur !== mon_last) begin
            if (sbq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL sb_unexpected: got %h, want no change from %h (edge %0d)", cur, mon_last, edge_n);
            end else begin
               ev = sbq.pop_front();
               chk("sb_value", {4'h0, cur}, {4'h0, ev.rgb, ev.idx});
               chk("sb_edge", edge_n, ev.e);
            end
            mon_last = cur;
         end
      end
      if (wrap_o === 1'b1) begin
         wraps++;
         chk("wrap_edge", edge_n, wrap_edge);
      end
   end

   initial begin
      sync = 1'b1;
      forever begin
         @(negedge clk);
         sync = sync_periodic ? (edge_n % 16 == 15) : 1'b1;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, want $finish");
      $fatal(1);
   end

   initial begin
      int          e0, nc, adv, last_e;
      logic [23:0] c;
      logic [3:0]  idx;

      pal = '{24'hFF0000, 24'hFF4000, 24'hFF5500, 24'hFF8000, 24'hFFD500,
              24'h00FF00, 24'h99FF99, 24'h00CCAA, 24'h4DC3FF, 24'h0066CC,
              24'h0000FF, 24'hB3CCFF, 24'hFFE6FB, 24'hFF80BF, 24'hFF3399};
      add_vec("start",       0,   24'hFF0000, 4'd1, 1'b1);
      add_vec("pre_commit",  4,   24'hFF0000, 4'd1, 1'b1);
      add_vec("first_step",  5,   24'hFF0100, 4'd1, 1'b1);
      add_vec("second_step", 9,   24'hFF0200, 4'd1, 1'b1);
      add_vec("reach_40",    257, 24'hFF4000, 4'd1, 1'b1);
      add_vec("hold_end",    264, 24'hFF4000, 4'd1, 1'b1);
      add_vec("advance_2",   265, 24'hFF4000, 4'd2, 1'b1);
      add_vec("fade2_step",  269, 24'hFF4100, 4'd2, 1'b1);
      add_vec("reach_55",    349, 24'hFF5500, 4'd2, 1'b1);
      add_vec("advance_3",   357, 24'hFF5500, 4'd3, 1'b1);

      // Reset state
      rst = 1'b0; en = 1'b0; pause = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_red",   red_o,   8'hFF);
      chk("rst_green", green_o, 8'h00);
      chk("rst_blue",  blue_o,  8'h00);
      chk("rst_index", index_o, 4'd0);
      chk("rst_busy",  busy,    1'b0);
      chk("rst_wrap",  wrap_o,  1'b0);
      rst = 1'b1;
      @(negedge clk);

      // Full palette cycle with sync tied high, through the 14->0 wrap
      mon_last = {24'hFF0000, 4'd0};
      mon_on = 1'b1;
      en = 1'b1;
      @(posedge clk); #1;
      e0 = edge_n;
      c = 24'hFF0000; idx = 4'd1; nc = e0 + 5; last_e = e0;
      push(e0, c, idx);
      for (int t = 0; t < 15; t++) begin
         while (c != pal[idx]) begin
            c = step_rgb(c, pal[idx]);
            push(nc, c, idx);
            last_e = nc;
            nc += STEP_DIV;
         end
         if (t < 14) begin
            adv = nc + STEP_DIV * (HOLD - 1);
            idx = (idx == 4'd14) ? 4'd0 : idx + 4'd1;
            if (idx == 4'd0) wrap_edge = adv;
            push(adv, c, idx);
            nc = adv + STEP_DIV;
         end
      end
      for (int i = 0; i < vt.size(); i++) begin
         wait_edge(e0 + vt[i].ofs);
         en = vt[i].en; pause = vt[i].pause;
         chk({vt[i].name, "_rgb"},  {red_o, green_o, blue_o}, vt[i].rgb);
         chk({vt[i].name, "_idx"},  index_o, vt[i].idx);
         chk({vt[i].name, "_busy"}, busy, vt[i].busy);
      end
      wait_edge(last_e + 2);
      mon_on = 1'b0;
      chk("main_drain", sbq.size(), 0);
      chk("wrap_count", wraps, 1);
      chk("main_end_rgb", {red_o, green_o, blue_o}, 24'hFF0000);

      // Periodic sync every 16 cycles: one step per sync, no accumulation
      en = 1'b0; rst = 1'b0; sync_periodic = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      sbq.delete();
      mon_last = {24'hFF0000, 4'd0};
      mon_on = 1'b1;
      en = 1'b1;
      @(posedge clk); #1;
      e0 = edge_n;
      push(e0, 24'hFF0000, 4'd1);
      nc = ((e0 + 5 + 15) / 16) * 16;
      c = 24'hFF0000;
      for (int k = 0; k < 8; k++) begin
         c = step_rgb(c, 24'hFF4000);
         push(nc, c, 4'd1);
         nc += 16;
      end
      wait_edge(nc - 16 + 2);
      mon_on = 1'b0;
      chk("sync_drain", sbq.size(), 0);

      // Asynchronous reset mid-fade, between clock edges
      @(posedge clk); #2;
      rst = 1'b0;
      #1;
      chk("arst_red",   red_o,   8'hFF);
      chk("arst_green", green_o, 8'h00);
      chk("arst_blue",  blue_o,  8'h00);
      chk("arst_index", index_o, 4'd0);
      chk("arst_busy",  busy,    1'b0);
      en = 1'b0;
      sync_periodic = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      // Pause mid-fade, disable, re-enable toward next index, disable on a commit edge
      mon_last = {24'hFF0000, 4'd0};
      mon_on = 1'b1;
      en = 1'b1;
      @(posedge clk); #1;
      e0 = edge_n;
      push(e0,      24'hFF0000, 4'd1);
      push(e0 + 5,  24'hFF0100, 4'd1);
      push(e0 + 9,  24'hFF0200, 4'd1);
      push(e0 + 13, 24'hFF0300, 4'd1);
      wait_edge(e0 + 14);
      pause = 1'b1;
      repeat (20) @(negedge clk);
      chk("pause_rgb", {red_o, green_o, blue_o}, 24'hFF0300);
      en = 1'b0; pause = 1'b0;
      @(negedge clk);
      chk("dis_busy", busy, 1'b0);
      chk("dis_rgb", {red_o, green_o, blue_o}, 24'hFF0300);
      chk("dis_idx", index_o, 4'd1);
      repeat (5) @(negedge clk);
      chk("idle_rgb", {red_o, green_o, blue_o}, 24'hFF0300);
      en = 1'b1;
      @(posedge clk); #1;
      e0 = edge_n;
      push(e0,     24'hFF0300, 4'd2);
      push(e0 + 5, 24'hFF0400, 4'd2);
      push(e0 + 9, 24'hFF0500, 4'd2);
      wait_edge(e0 + 12);
      en = 1'b0;
      wait_edge(e0 + 20);
      mon_on = 1'b0;
      chk("race_busy", busy, 1'b0);
      chk("race_rgb", {red_o, green_o, blue_o}, 24'hFF0500);
      chk("race_idx", index_o, 4'd2);
      chk("pause_drain", sbq.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
